p405s_xer_ckpt: RTL and testbench
=================================

Name: p405s_xer_ckpt

Overview:
Parametrised successor to the execute-stage XER holding register. Holds the architected XER fields SO, OV, CA and the TBC byte count, with TBC width set by a parameter. Adds a DEPTH-entry checkpoint ring for speculative execution past unresolved branches. Checkpoints are pushed at branch dispatch, retired in order at branch resolution, and restored by tag on mispredict flush. Sits in the EXE stage beside the CR/cc muxing and feeds the XER/TBC consumers.

Parameters:
TBC_W, 7, width of the XER byte-count field (EXE_xerTBC).
DEPTH, 4, number of checkpoint slots (power of two, >=2).
PTR_W, 2, log2(DEPTH); width of tags and pointers.

Ports:
CB  input  1  clock, rising edge.
resetL2  input  1  reset; asynchronous, active-high.
PCL_xerL2Hold  input  1  stall; blocks XER update, push and commit (flush is not blocked).
mtXer  input  1  mtspr to XER this cycle.
sprBusIn  input  32  mtspr data; SO=[0], OV=[1], CA=[2], TBC=[32-TBC_W:31].
PCL_exeMcrxr  input  1  mcrxr; clears SO/OV/CA.
PCL_exeXerOvEn  input  1  overflow-updating op.
nxtOv  input  1  qualified overflow result.
PCL_exeXerCaEn  input  1  carry-updating op.
nxtCa  input  1  qualified carry result.
dlmzb  input  1  dlmzb op; loads TBC.
dlmzbCnt  input  TBC_W  dlmzb byte count.
ckptPush  input  1  allocate checkpoint of current XER.
ckptCommit  input  1  retire oldest checkpoint.
ckptFlush  input  1  mispredict; restore from flushTag.
flushTag  input  PTR_W  slot to restore.
EXE_xer  output  3  {SO,OV,CA} registered.
EXE_xerTBC  output  TBC_W  registered TBC.
EXE_xerTBCNotEqZero  output  1  registered (TBC != 0).
ckptTag  output  PTR_W  tag given to a push this cycle (= tail pointer).
ckptCount  output  PTR_W+1  occupied slots.
ckptFull  output  1  ckptCount == DEPTH.
ckptEmpty  output  1  ckptCount == 0.
ckptErr  output  1  sticky: push-when-full or flush with invalid tag.

Behaviour:
- Reset, asynchronous: EXE_xer=0, EXE_xerTBC=0, EXE_xerTBCNotEqZero=0, head=tail=0, ckptCount=0, ckptEmpty=1, ckptFull=0, ckptErr=0. Slot contents are don't-care.
- XER next value when not held and no flush. Priority, highest first:
  - mtXer: load all fields from sprBusIn.
  - PCL_exeMcrxr: SO=OV=CA=0; TBC unchanged.
  - Otherwise, per field:
    - OV = nxtOv if PCL_exeXerOvEn, else hold.
    - SO |= (PCL_exeXerOvEn & nxtOv). SO is sticky.
    - CA = nxtCa if PCL_exeXerCaEn, else hold.
    - TBC = dlmzbCnt if dlmzb, else hold.
- EXE_xerTBCNotEqZero is registered together with TBC from the next TBC value. There is no extra cycle of lag.
- All outputs update one cycle after the inputs that cause them. No combinational input-to-XER path.
- Push (not held, not full, no flush):
  - slot[tail] <= current registered XER (the value before this cycle's update).
  - ckptTag = tail; tail++ modulo DEPTH.
- Commit (not held, not empty, no flush): head++ modulo DEPTH.
- Push and commit in the same cycle: both take effect; count unchanged. When full, the commit frees a slot and the push is still accepted.
- Push when full: dropped; ckptErr <= 1.
- Commit when empty: ignored silently.
- Flush, valid tag (flushTag lies in the occupied range from head up to tail):
  - Overrides hold, push, commit and all XER update inputs that cycle.
  - XER <= slot[flushTag].
  - tail <= flushTag; ckptCount <= (flushTag - head) modulo DEPTH. The flushed slot and all younger slots are freed.
- Flush, invalid tag (outside the occupied range, or the ring is empty): no state change except ckptErr <= 1.
- Pointer wrap-around uses modulo-DEPTH arithmetic. Full and empty are told apart by ckptCount, not by comparing pointers.
- ckptErr clears only on reset.

Decomposition:
- Shared package p405s_xer_pkg holds:
  - typedef xer_t {so, ov, ca, tbc[TBC_W]};
  - field index constants XER_SO=0, XER_OV=1, XER_CA=2;
  - default TBC_W.
- One natural sub-module: p405s_xer_ckpt_ring. It holds the slot storage, head/tail/count, full/empty and tag-validity check, and it exposes the restore data.

Test Plan:
- Reset mid-operation: push 2 checkpoints, assert resetL2 between clock edges -> all outputs 0 immediately; ckptEmpty=1.
- mtXer with sprBusIn=0xE000_0005 -> next cycle EXE_xer=3'b111, TBC=5, NotEqZero=1. Then mcrxr -> EXE_xer=0, TBC=5.
- Sticky SO: ovEn with nxtOv=1, then ovEn with nxtOv=0 -> EXE_xer=3'b100.
- Ring fill (DEPTH=4): 4 pushes -> tags 0,1,2,3, ckptFull=1. Fifth push -> ckptErr=1, count stays 4. Push+commit together -> count 4, new tag 0 (wrap).
- Speculative restore: XER=000, push (tag 1), then set CA and TBC=9, push (tag 2), then mtXer to 3'b111. Flush tag 1 -> EXE_xer=000, TBC as at tag 1, count = 1-head, tail=1.
- Invalid flush: head=2, tail=3, flushTag=0 -> no state change, ckptErr=1. Flush while PCL_xerL2Hold=1 with a valid tag -> restore still occurs.

Source files
------------

// File: rtl/p405s_xer_pkg.sv
// Shared XER definitions for the EXE-stage XER holding register and its checkpoint ring.
// Provides the default-width XER record, the IBM bit positions of SO/OV/CA in the
// mtspr data word, and the default TBC width.
package p405s_xer_pkg;

  // Default width of the XER byte-count field.
  localparam int XER_TBC_W = 7;

  // Field positions in IBM (MSB = 0) numbering of the 32-bit SPR bus.
  localparam int XER_SO = 0;
  localparam int XER_OV = 1;
  localparam int XER_CA = 2;

  typedef struct packed {
    logic                 so;
    logic                 ov;
    logic                 ca;
    logic [XER_TBC_W-1:0] tbc;
  } xer_t;

endpackage

// File: rtl/p405s_xer_ckpt_ring.sv
// Checkpoint ring: DEPTH slots of W-bit snapshots with head/tail/count bookkeeping.
// Ports: push/commit (already stall-qualified), flush + flush_tag, wr_dat snapshot in,
//        rd_dat = slot[flush_tag], tag_valid, tail_ptr (tag of next push), count/full/empty, err.
// Latency: state updates one cycle after the request; rd_dat/tag_valid are combinational.
// Backpressure: a push while full is dropped (unless a commit frees a slot the same cycle) and sets err.
module p405s_xer_ckpt_ring
  import p405s_xer_pkg::*;
#(
  parameter int W     = 3 + XER_TBC_W,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             commit,
  input  logic             flush,
  input  logic [PTR_W-1:0] flush_tag,
  input  logic [W-1:0]     wr_dat,
  output logic [W-1:0]     rd_dat,
  output logic             tag_valid,
  output logic [PTR_W-1:0] tail_ptr,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  logic [W-1:0]     slot [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] offset;
  logic             commit_acc;
  logic             push_acc;
  logic             push_err;
  logic             do_flush;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign tail_ptr = tail;
  assign rd_dat   = slot[flush_tag];

  // Distance of the tag from the oldest entry; DEPTH is a power of two so the
  // subtraction wraps exactly modulo DEPTH. Valid tags lie strictly below count.
  assign offset    = flush_tag - head;
  assign tag_valid = ({1'b0, offset} < count);

  // Any flush, valid or not, freezes the normal push/commit traffic that cycle.
  assign do_flush   = flush & tag_valid;
  assign commit_acc = commit & ~flush & ~empty;
  // When full, a simultaneous commit frees the slot this push lands in.
  assign push_acc   = push & ~flush & (~full | commit_acc);
  assign push_err   = push & ~flush & full & ~commit_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (push_err || (flush && !tag_valid)) begin
        err <= 1'b1;
      end
      if (do_flush) begin
        tail  <= flush_tag;
        count <= {1'b0, offset};
      end else begin
        if (push_acc) begin
          tail <= tail + PTR_W'(1);
        end
        if (commit_acc) begin
          head <= head + PTR_W'(1);
        end
        case ({push_acc, commit_acc})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Slot contents need no reset: a slot is only read back once it has been written.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      slot[tail] <= wr_dat;
    end
  end

endmodule

// File: rtl/p405s_xer_ckpt.sv
// EXE-stage XER (SO/OV/CA/TBC) holding register with a speculative checkpoint ring.
// Ports: CB/resetL2; stall; mtspr, mcrxr, ov/ca/dlmzb update controls; push/commit/flush
//        checkpoint controls; registered XER outputs and ring status (tag, count, full, empty, err).
// Latency: every output changes one cycle after its cause. Backpressure: stall blocks
// XER update, push and commit but never a flush; pushes into a full ring are dropped and flagged.
module p405s_xer_ckpt
  import p405s_xer_pkg::*;
#(
  parameter int TBC_W = XER_TBC_W,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CB,
  input  logic             resetL2,
  input  logic             PCL_xerL2Hold,
  input  logic             mtXer,
  input  logic [31:0]      sprBusIn,
  input  logic             PCL_exeMcrxr,
  input  logic             PCL_exeXerOvEn,
  input  logic             nxtOv,
  input  logic             PCL_exeXerCaEn,
  input  logic             nxtCa,
  input  logic             dlmzb,
  input  logic [TBC_W-1:0] dlmzbCnt,
  input  logic             ckptPush,
  input  logic             ckptCommit,
  input  logic             ckptFlush,
  input  logic [PTR_W-1:0] flushTag,
  output logic [2:0]       EXE_xer,
  output logic [TBC_W-1:0] EXE_xerTBC,
  output logic             EXE_xerTBCNotEqZero,
  output logic [PTR_W-1:0] ckptTag,
  output logic [PTR_W:0]   ckptCount,
  output logic             ckptFull,
  output logic             ckptEmpty,
  output logic             ckptErr
);

  // Same layout as xer_t, but sized by this instance's TBC width.
  typedef struct packed {
    logic             so;
    logic             ov;
    logic             ca;
    logic [TBC_W-1:0] tbc;
  } xer_rec_t;

  xer_rec_t xer_q;
  xer_rec_t xer_d;
  xer_rec_t restore_dat;
  logic     tbc_nz_q;
  logic     tag_valid;
  logic     upd_en;
  logic     spr_unused;

  // Bits between CA and the TBC field carry nothing this register holds.
  assign spr_unused = ^sprBusIn[28:TBC_W];

  assign upd_en = ~PCL_xerL2Hold & ~ckptFlush;

  always_comb begin
    xer_d = xer_q;
    if (ckptFlush && tag_valid) begin
      xer_d = restore_dat;
    end else if (upd_en) begin
      if (mtXer) begin
        xer_d.so  = sprBusIn[31-XER_SO];
        xer_d.ov  = sprBusIn[31-XER_OV];
        xer_d.ca  = sprBusIn[31-XER_CA];
        xer_d.tbc = sprBusIn[TBC_W-1:0];
      end else if (PCL_exeMcrxr) begin
        xer_d.so = 1'b0;
        xer_d.ov = 1'b0;
        xer_d.ca = 1'b0;
      end else begin
        if (PCL_exeXerOvEn) begin
          xer_d.ov = nxtOv;
          xer_d.so = xer_q.so | nxtOv;
        end
        if (PCL_exeXerCaEn) begin
          xer_d.ca = nxtCa;
        end
        if (dlmzb) begin
          xer_d.tbc = dlmzbCnt;
        end
      end
    end
  end

  // The zero flag is computed from the next TBC so it lands in the same cycle as TBC.
  always_ff @(posedge CB or posedge resetL2) begin
    if (resetL2) begin
      xer_q    <= '0;
      tbc_nz_q <= 1'b0;
    end else begin
      xer_q    <= xer_d;
      tbc_nz_q <= (xer_d.tbc != '0);
    end
  end

  assign EXE_xer             = {xer_q.so, xer_q.ov, xer_q.ca};
  assign EXE_xerTBC          = xer_q.tbc;
  assign EXE_xerTBCNotEqZero = tbc_nz_q;

  // Snapshots capture the registered XER, i.e. the value before this cycle's update.
  p405s_xer_ckpt_ring #(
    .W     ($bits(xer_rec_t)),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ring (
    .clk       (CB),
    .rst       (resetL2),
    .push      (ckptPush & ~PCL_xerL2Hold),
    .commit    (ckptCommit & ~PCL_xerL2Hold),
    .flush     (ckptFlush),
    .flush_tag (flushTag),
    .wr_dat    (xer_q),
    .rd_dat    (restore_dat),
    .tag_valid (tag_valid),
    .tail_ptr  (ckptTag),
    .count     (ckptCount),
    .full      (ckptFull),
    .empty     (ckptEmpty),
    .err       (ckptErr)
  );

endmodule

// File: tb/tb_p405s_xer_ckpt.sv
module tb_p405s_xer_ckpt;

  logic        CB;
  logic        resetL2;
  logic        PCL_xerL2Hold;
  logic        mtXer;
  logic [31:0] sprBusIn;
  logic        PCL_exeMcrxr;
  logic        PCL_exeXerOvEn;
  logic        nxtOv;
  logic        PCL_exeXerCaEn;
  logic        nxtCa;
  logic        dlmzb;
  logic [6:0]  dlmzbCnt;
  logic        ckptPush;
  logic        ckptCommit;
  logic        ckptFlush;
  logic [1:0]  flushTag;
  logic [2:0]  EXE_xer;
  logic [6:0]  EXE_xerTBC;
  logic        EXE_xerTBCNotEqZero;
  logic [1:0]  ckptTag;
  logic [2:0]  ckptCount;
  logic        ckptFull;
  logic        ckptEmpty;
  logic        ckptErr;

  int nvec;
  int nerr;

  p405s_xer_ckpt #(.TBC_W(7), .DEPTH(4), .PTR_W(2)) dut (
    .CB                  (CB),
    .resetL2             (resetL2),
    .PCL_xerL2Hold       (PCL_xerL2Hold),
    .mtXer               (mtXer),
    .sprBusIn            (sprBusIn),
    .PCL_exeMcrxr        (PCL_exeMcrxr),
    .PCL_exeXerOvEn      (PCL_exeXerOvEn),
    .nxtOv               (nxtOv),
    .PCL_exeXerCaEn      (PCL_exeXerCaEn),
    .nxtCa               (nxtCa),
    .dlmzb               (dlmzb),
    .dlmzbCnt            (dlmzbCnt),
    .ckptPush            (ckptPush),
    .ckptCommit          (ckptCommit),
    .ckptFlush           (ckptFlush),
    .flushTag            (flushTag),
    .EXE_xer             (EXE_xer),
    .EXE_xerTBC          (EXE_xerTBC),
    .EXE_xerTBCNotEqZero (EXE_xerTBCNotEqZero),
    .ckptTag             (ckptTag),
    .ckptCount           (ckptCount),
    .ckptFull            (ckptFull),
    .ckptEmpty           (ckptEmpty),
    .ckptErr             (ckptErr)
  );

  initial CB = 1'b0;
  always #5 CB = ~CB;

  typedef struct {
    logic        hold;
    logic        mt;
    logic [31:0] spr;
    logic        mcrxr;
    logic        oven;
    logic        nov;
    logic        caen;
    logic        nca;
    logic        dl;
    logic [6:0]  cnt;
    logic [2:0]  exp_xer;
    logic [6:0]  exp_tbc;
    logic        exp_nz;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_xer(input string name, input logic [2:0] x, input logic [6:0] t, input logic nz);
    chk({name, ".xer"}, {29'd0, EXE_xer}, {29'd0, x});
    chk({name, ".tbc"}, {25'd0, EXE_xerTBC}, {25'd0, t});
    chk({name, ".nz"}, {31'd0, EXE_xerTBCNotEqZero}, {31'd0, nz});
  endtask

  task automatic chk_ring(input string name, input logic [2:0] cnt, input logic [1:0] tag,
                          input logic full, input logic empty, input logic err);
    chk({name, ".count"}, {29'd0, ckptCount}, {29'd0, cnt});
    chk({name, ".tag"}, {30'd0, ckptTag}, {30'd0, tag});
    chk({name, ".full"}, {31'd0, ckptFull}, {31'd0, full});
    chk({name, ".empty"}, {31'd0, ckptEmpty}, {31'd0, empty});
    chk({name, ".err"}, {31'd0, ckptErr}, {31'd0, err});
  endtask

  task automatic clr_inputs();
    PCL_xerL2Hold  = 1'b0;
    mtXer          = 1'b0;
    sprBusIn       = 32'd0;
    PCL_exeMcrxr   = 1'b0;
    PCL_exeXerOvEn = 1'b0;
    nxtOv          = 1'b0;
    PCL_exeXerCaEn = 1'b0;
    nxtCa          = 1'b0;
    dlmzb          = 1'b0;
    dlmzbCnt       = 7'd0;
    ckptPush       = 1'b0;
    ckptCommit     = 1'b0;
    ckptFlush      = 1'b0;
    flushTag       = 2'd0;
  endtask

  // Let one rising edge consume the driven inputs, then sample 1 time unit later.
  task automatic tick();
    @(posedge CB);
    #1;
    clr_inputs();
  endtask

  // Ring operation; any XER inputs set by the caller beforehand are applied too.
  task automatic ring(input logic push, input logic commit, input logic flush,
                      input logic [1:0] tag, input logic hold);
    ckptPush      = push;
    ckptCommit    = commit;
    ckptFlush     = flush;
    flushTag      = tag;
    PCL_xerL2Hold = hold;
    tick();
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    clr_inputs();
    resetL2 = 1'b1;

    //              hold mt  spr           mcr oven nov caen nca dl  cnt     xer     tbc     nz
    vecs[0]  = '{1'b0, 1'b1, 32'hE000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   3'b111, 7'd5,   1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   3'b000, 7'd5,   1'b1};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0,   3'b110, 7'd5,   1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   3'b100, 7'd5,   1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0,   3'b101, 7'd5,   1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0,   3'b101, 7'd0,   1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'd127, 3'b100, 7'd127, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h4000_0003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   3'b010, 7'd3,   1'b1};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'd9,   3'b000, 7'd3,   1'b1};
    vecs[9]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   3'b000, 7'd3,   1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   3'b001, 7'd0,   1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0,   3'b001, 7'd0,   1'b0};

    #12;
    chk_xer("reset", 3'b000, 7'd0, 1'b0);
    chk_ring("reset", 3'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    @(posedge CB);
    #1;
    resetL2 = 1'b0;

    // XER update priorities and sticky SO.
    for (int i = 0; i < 12; i++) begin
      PCL_xerL2Hold  = vecs[i].hold;
      mtXer          = vecs[i].mt;
      sprBusIn       = vecs[i].spr;
      PCL_exeMcrxr   = vecs[i].mcrxr;
      PCL_exeXerOvEn = vecs[i].oven;
      nxtOv          = vecs[i].nov;
      PCL_exeXerCaEn = vecs[i].caen;
      nxtCa          = vecs[i].nca;
      dlmzb          = vecs[i].dl;
      dlmzbCnt       = vecs[i].cnt;
      tick();
      chk_xer($sformatf("vec%0d", i), vecs[i].exp_xer, vecs[i].exp_tbc, vecs[i].exp_nz);
    end

    // Fill the ring: tags 0..3, then full.
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_tag%0d", i), {30'd0, ckptTag}, i);
      ring(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    end
    chk_ring("full", 3'd4, 2'd0, 1'b1, 1'b0, 1'b0);
    ring(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    chk_ring("push_full", 3'd4, 2'd0, 1'b1, 1'b0, 1'b1);
    ring(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    chk_ring("push_commit_full", 3'd4, 2'd1, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-operation, between edges.
    #2;
    resetL2 = 1'b1;
    #1;
    chk_xer("async_reset", 3'b000, 7'd0, 1'b0);
    chk_ring("async_reset", 3'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    @(posedge CB);
    #1;
    resetL2 = 1'b0;

    // Speculative restore.
    ring(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    ring(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk_ring("spec_setup", 3'd0, 2'd1, 1'b0, 1'b1, 1'b0);
    dlmzb = 1'b1; dlmzbCnt = 7'd4;
    tick();
    chk_xer("spec_tbc4", 3'b000, 7'd4, 1'b1);
    ring(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    PCL_exeXerCaEn = 1'b1; nxtCa = 1'b1; dlmzb = 1'b1; dlmzbCnt = 7'd9;
    tick();
    chk_xer("spec_ca_tbc9", 3'b001, 7'd9, 1'b1);
    chk("spec_tag2", {30'd0, ckptTag}, 32'd2);
    ring(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    mtXer = 1'b1; sprBusIn = 32'hE000_0000;
    tick();
    chk_xer("spec_mt", 3'b111, 7'd0, 1'b0);
    chk_ring("spec_two", 3'd2, 2'd3, 1'b0, 1'b0, 1'b0);
    // Flush overrides a concurrent mtXer and push.
    mtXer = 1'b1; sprBusIn = 32'hFFFF_FFFF;
    ring(1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
    chk_xer("flush_tag2", 3'b001, 7'd9, 1'b1);
    chk_ring("flush_tag2", 3'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    ring(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    chk_xer("flush_tag1", 3'b000, 7'd4, 1'b1);
    chk_ring("flush_tag1", 3'd0, 2'd1, 1'b0, 1'b1, 1'b0);

    // Invalid flush with head=2, tail=3, then a flush under stall.
    ring(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    mtXer = 1'b1; sprBusIn = 32'h8000_0011;
    tick();
    chk_xer("inv_mt", 3'b100, 7'd17, 1'b1);
    ring(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    ring(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    mtXer = 1'b1; sprBusIn = 32'h2000_0000;
    tick();
    chk_xer("inv_setup", 3'b001, 7'd0, 1'b0);
    chk_ring("inv_setup", 3'd1, 2'd3, 1'b0, 1'b0, 1'b0);
    mtXer = 1'b1; sprBusIn = 32'hFFFF_FFFF;
    ring(1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    chk_xer("inv_flush0", 3'b001, 7'd0, 1'b0);
    chk_ring("inv_flush0", 3'd1, 2'd3, 1'b0, 1'b0, 1'b1);
    ring(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    chk_ring("inv_flush1", 3'd1, 2'd3, 1'b0, 1'b0, 1'b1);
    ring(1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
    chk_xer("hold_flush2", 3'b100, 7'd17, 1'b1);
    chk_ring("hold_flush2", 3'd0, 2'd2, 1'b0, 1'b1, 1'b1);
    ring(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    chk_ring("hold_push", 3'd0, 2'd2, 1'b0, 1'b1, 1'b1);
    ring(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk_ring("commit_empty", 3'd0, 2'd2, 1'b0, 1'b1, 1'b1);
    chk_xer("final", 3'b100, 7'd17, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
